gate_bist: RTL

On-chip built-in self-test engine for the combinational logic library (not16, and16, or16, mux16, or8way, mux4way16, mux8way16, dmux4way, dmux8way). Its job is the hardware counterpart of the simulation checker: it generates stimulus, drives the structural gates, computes golden results behaviourally, compares the two, and reports a pass/fail verdict. It sits beside the gate library on the iCE40 image and is started from the board control logic.

---
 rtl/hack_bist_pkg.sv | 103 ++++++++++
 rtl/lfsr16.sv | 26 ++
 rtl/gate_bist.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hack_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_bist_pkg
// Purpose  : Shared constants, result record and NAND-composed gate models
//            for the gate-library BIST engine. Optional: GATE_BIST_MUX8_EN.
// Revision : 1.0  initial release
// ============================================================================
package hack_bist_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] OP_XOR_C  = 16'hA5A5;
   localparam logic [15:0] OP_XOR_G  = 16'h00FF;

   localparam int FM_NOT16  = 0;
   localparam int FM_AND16  = 1;
   localparam int FM_OR16   = 2;
   localparam int FM_MUX16  = 3;
   localparam int FM_OR8WAY = 4;
   localparam int FM_MUX4   = 5;
   localparam int FM_MUX8   = 6;
   localparam int FM_DMUX   = 7;

   typedef struct packed {
      logic [15:0] not_o;
      logic [15:0] and_o;
      logic [15:0] or_o;
      logic [15:0] mux_o;
      logic        or8_o;
      logic [15:0] mux4_o;
`ifdef GATE_BIST_MUX8_EN
      logic [15:0] mux8_o;
      logic [7:0]  dmux8_o;
`endif
      logic [3:0]  dmux4_o;
   } res_t;

   // Every gate below is built only from NAND so it is independent of the
   // operator-based golden model it is checked against.
   function automatic logic [15:0] nand16(input logic [15:0] x, input logic [15:0] y);
      return ~(x & y);
   endfunction
   function automatic logic [15:0] not16(input logic [15:0] x);
      return nand16(x, x);
   endfunction
   function automatic logic [15:0] and16(input logic [15:0] x, input logic [15:0] y);
      return not16(nand16(x, y));
   endfunction
   function automatic logic [15:0] or16(input logic [15:0] x, input logic [15:0] y);
      return nand16(not16(x), not16(y));
   endfunction
   function automatic logic [15:0] mux16(input logic [15:0] x, input logic [15:0] y,
                                         input logic s);
      return nand16(nand16(x, not16({16{s}})), nand16(y, {16{s}}));
   endfunction
   function automatic logic nand1(input logic x, input logic y);
      return ~(x & y);
   endfunction
   function automatic logic and1(input logic x, input logic y);
      return nand1(nand1(x, y), nand1(x, y));
   endfunction
   function automatic logic or1(input logic x, input logic y);
      return nand1(nand1(x, x), nand1(y, y));
   endfunction
   function automatic logic or8way(input logic [7:0] x);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 8; i++) r = or1(r, x[i]);
      return r;
   endfunction
   function automatic logic [15:0] mux4way16(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] d,
                                             input logic [1:0] s);
      return mux16(mux16(a, b, s[0]), mux16(c, d, s[0]), s[1]);
   endfunction
   function automatic logic [15:0] mux8way16(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] d,
                                             input logic [15:0] e, input logic [15:0] f,
                                             input logic [15:0] g, input logic [15:0] h,
                                             input logic [2:0] s);
      return mux16(mux4way16(a, b, c, d, s[1:0]), mux4way16(e, f, g, h, s[1:0]), s[2]);
   endfunction
   function automatic logic [1:0] dmux2(input logic x, input logic s);
      return {and1(x, s), and1(x, nand1(s, s))};
   endfunction
   function automatic logic [3:0] dmux4way(input logic x, input logic [1:0] s);
      logic [1:0] t;
      t = dmux2(x, s[1]);
      return {dmux2(t[1], s[0]), dmux2(t[0], s[0])};
   endfunction
   function automatic logic [7:0] dmux8way(input logic x, input logic [2:0] s);
      logic [1:0] t;
      t = dmux2(x, s[2]);
      return {dmux4way(t[1], s[1:0]), dmux4way(t[0], s[1:0])};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit Galois LFSR stimulus source, reloadable with the seed.
// Revision : 1.0  initial release
// ============================================================================
module lfsr16
   import hack_bist_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      if (reset || load) begin
         q <= LFSR_SEED;
      end else if (step) begin
         q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule
`default_nettype wire

// File: rtl/gate_bist.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist
// Purpose  : Self-test engine comparing NAND-built gates against golden
//            operators. Optional macro GATE_BIST_MUX8_EN adds the 8-way parts.
// Revision : 1.0  initial release
// ============================================================================
module gate_bist
   import hack_bist_pkg::*;
#(
   parameter int NUM_VECTORS = 1024,
   parameter int FAIL_STOP   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        inject_en,
   input  logic [15:0] inject_vec,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] fail_vec,
   output logic [7:0]  fail_mask
);

   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

   logic [1:0]  state;
   logic [15:0] vec_idx;
   logic [15:0] lfsr_q;
   logic        issue;
   logic        launch;
   logic        s0_vld;
   logic [15:0] s0_w;
   logic [15:0] s0_idx;
   logic        s1_vld;
   logic [15:0] s1_idx;
   res_t        gold;
   res_t        dut;
   res_t        s1_gold;
   res_t        s1_dut;
   logic        inj;
   logic [7:0]  mism;

   assign issue  = (state == ST_RUN);
   assign launch = start && ((state == ST_IDLE) || (state == ST_DONE));

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (launch),
      .step  (issue),
      .q     (lfsr_q)
   );

   logic [15:0]       op_a, op_b, op_c, op_d;
   logic [3:0][15:0]  m4_src;
   assign op_a   = s0_w;
   assign op_b   = {s0_w[7:0], s0_w[15:8]};
   assign op_c   = s0_w ^ OP_XOR_C;
   assign op_d   = ~s0_w;
   assign m4_src = {op_d, op_c, op_b, op_a};
`ifdef GATE_BIST_MUX8_EN
   logic [15:0]       op_e, op_f, op_g, op_h;
   logic [7:0][15:0]  m8_src;
   assign op_e   = {s0_w[12:0], s0_w[15:13]};
   assign op_f   = {s0_w[8:0], s0_w[15:9]};
   assign op_g   = s0_w ^ OP_XOR_G;
   assign op_h   = s0_w + 16'd1;
   assign m8_src = {op_h, op_g, op_f, op_e, op_d, op_c, op_b, op_a};
`endif

   always_comb begin
      gold                     = '0;
      gold.not_o               = ~op_a;
      gold.and_o               = op_a & op_b;
      gold.or_o                = op_a | op_c;
      gold.mux_o               = s0_idx[0] ? op_b : op_a;
      gold.or8_o               = |op_a[7:0];
      gold.mux4_o              = m4_src[s0_idx[1:0]];
      gold.dmux4_o[s0_idx[1:0]] = s0_w[0];
`ifdef GATE_BIST_MUX8_EN
      gold.mux8_o              = m8_src[s0_idx[2:0]];
      gold.dmux8_o[s0_idx[2:0]] = s0_w[0];
`endif
   end

   always_comb begin
      dut         = '0;
      dut.not_o   = not16(op_a);
      dut.and_o   = and16(op_a, op_b);
      dut.or_o    = or16(op_a, op_c);
      dut.mux_o   = mux16(op_a, op_b, s0_idx[0]);
      dut.or8_o   = or8way(op_a[7:0]);
      dut.mux4_o  = mux4way16(op_a, op_b, op_c, op_d, s0_idx[1:0]);
      dut.dmux4_o = dmux4way(s0_w[0], s0_idx[1:0]);
`ifdef GATE_BIST_MUX8_EN
      dut.mux8_o  = mux8way16(op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h, s0_idx[2:0]);
      dut.dmux8_o = dmux8way(s0_w[0], s0_idx[2:0]);
`endif
   end

   assign inj = inject_en && (s1_idx == inject_vec);

   always_comb begin
      mism            = '0;
      mism[FM_NOT16]  = (s1_dut.not_o ^ {15'd0, inj}) != s1_gold.not_o;
      mism[FM_AND16]  = s1_dut.and_o  != s1_gold.and_o;
      mism[FM_OR16]   = s1_dut.or_o   != s1_gold.or_o;
      mism[FM_MUX16]  = s1_dut.mux_o  != s1_gold.mux_o;
      mism[FM_OR8WAY] = s1_dut.or8_o  != s1_gold.or8_o;
      mism[FM_MUX4]   = s1_dut.mux4_o != s1_gold.mux4_o;
      mism[FM_DMUX]   = s1_dut.dmux4_o != s1_gold.dmux4_o;
`ifdef GATE_BIST_MUX8_EN
      mism[FM_MUX8]   = s1_dut.mux8_o != s1_gold.mux8_o;
      mism[FM_DMUX]   = mism[FM_DMUX] || (s1_dut.dmux8_o != s1_gold.dmux8_o);
`endif
      if (!s1_vld) mism = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         vec_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_vec  <= '0;
         fail_mask <= '0;
         s0_vld    <= 1'b0;
         s1_vld    <= 1'b0;
      end else begin
         s0_vld  <= issue;
         s0_w    <= lfsr_q;
         s0_idx  <= vec_idx;
         s1_vld  <= s0_vld;
         s1_idx  <= s0_idx;
         s1_gold <= gold;
         s1_dut  <= dut;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_RUN;
                  vec_idx   <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  fail_vec  <= '0;
                  fail_mask <= '0;
               end
            end
            ST_RUN: begin
               if (vec_idx == LAST_IDX) state <= ST_DRAIN;
               else                     vec_idx <= vec_idx + 16'd1;
            end
            default: ;
         endcase
         // Compare stage: overrides the sequencing above when the run ends here.
         if (s1_vld) begin
            if (mism != 8'h00) begin
               fail_mask <= fail_mask | mism;
               if (fail_mask == 8'h00) fail_vec <= s1_idx;
            end
            if (((mism != 8'h00) && (FAIL_STOP != 0)) || (s1_idx == LAST_IDX)) begin
               state  <= ST_DONE;
               busy   <= 1'b0;
               done   <= 1'b1;
               pass   <= ((fail_mask | mism) == 8'h00);
               s0_vld <= 1'b0;
               s1_vld <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire
